// File: rtl/load_store_unit.sv
`timescale 1ns/1ps
// load_store_unit: sub-word RISC-V load/store front end for a word-wide Data_Memory.
// Loads and word stores complete in one cycle. Byte and halfword stores do a
// read-modify-write: the word is read and merged in IDLE, then written in WRITE.
// Optional feature: define LSU_MISALIGN_TRAP_EN to trap misaligned halfword and
// word accesses (accepted, no memory access, rsp_misalign reported).
module load_store_unit #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_misalign,
  output logic [ADDR_W-1:0] mem_A,
  output logic [31:0]       mem_WD,
  output logic              mem_MemWrite,
  input  logic [31:0]       mem_RD
);

  typedef enum logic {IDLE, WRITE} state_t;

  state_t            state;
  logic [ADDR_W-1:0] wr_addr_p1;
  logic [31:0]       wr_data_p1;
  logic              vld_p1;
  logic [31:0]       rdata_p1;
  logic              mis_p1;

  logic              fire;
  logic              legal;
  logic              is_word;
  logic              is_half;
  logic              misalign;
  logic              store_w_fire;
  logic              store_sub_fire;
  logic [ADDR_W-1:0] word_addr;

  // Lane-select and sign/zero-extend a load result. Halfwords use off[1] only.
  function automatic logic [31:0] load_extend(input logic [31:0] w,
                                              input logic [2:0]  f3,
                                              input logic [1:0]  off);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = w[{off, 3'b000} +: 8];
    h = w[{off[1], 4'b0000} +: 16];
    case (f3)
      3'b000:  r = {{24{b[7]}}, b};
      3'b001:  r = {{16{h[15]}}, h};
      3'b010:  r = w;
      3'b100:  r = {24'h0, b};
      3'b101:  r = {16'h0, h};
      default: r = 32'h0;
    endcase
    return r;
  endfunction

  // Replace the addressed byte or halfword lane of the old word with store data.
  function automatic logic [31:0] store_merge(input logic [31:0] w,
                                              input logic [31:0] wd,
                                              input logic [2:0]  f3,
                                              input logic [1:0]  off);
    logic [31:0] r;
    r = w;
    if (f3[1:0] == 2'b00)
      r[{off, 3'b000} +: 8] = wd[7:0];
    else
      r[{off[1], 4'b0000} +: 16] = wd[15:0];
    return r;
  endfunction

  assign word_addr = {req_addr[ADDR_W-1:2], 2'b00};
  assign legal     = !((req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11));
  assign is_word   = (req_funct3[1:0] == 2'b10);
  assign is_half   = (req_funct3[1:0] == 2'b01);

`ifdef LSU_MISALIGN_TRAP_EN
  assign misalign = (is_half & req_addr[0]) | (is_word & (req_addr[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  assign req_ready      = ~rst & (state == IDLE);
  assign fire           = req_valid & req_ready;
  assign store_w_fire   = fire & req_we & legal & ~misalign & is_word;
  assign store_sub_fire = fire & req_we & legal & ~misalign & ~is_word;

  assign rsp_valid    = vld_p1;
  assign rsp_rdata    = rdata_p1;
  assign rsp_misalign = mis_p1;

  // Memory port: WRITE replays the merged word, IDLE passes the request through.
  always_comb begin
    mem_A        = '0;
    mem_WD       = '0;
    mem_MemWrite = 1'b0;
    if (!rst) begin
      if (state == WRITE) begin
        mem_A        = wr_addr_p1;
        mem_WD       = wr_data_p1;
        mem_MemWrite = 1'b1;
      end else begin
        mem_A        = word_addr;
        mem_WD       = req_wdata;
        mem_MemWrite = store_w_fire;
      end
    end
  end

  // Control FSM with registered response; a sub-word store detours through WRITE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      vld_p1   <= 1'b0;
      rdata_p1 <= '0;
      mis_p1   <= 1'b0;
    end else begin
      vld_p1   <= 1'b0;
      rdata_p1 <= '0;
      mis_p1   <= 1'b0;
      case (state)
        IDLE: begin
          if (fire) begin
            if (!legal || misalign) begin
              vld_p1 <= 1'b1;
              mis_p1 <= legal & misalign;
            end else if (!req_we) begin
              vld_p1   <= 1'b1;
              rdata_p1 <= load_extend(mem_RD, req_funct3, req_addr[1:0]);
            end else if (is_word) begin
              vld_p1 <= 1'b1;
            end else begin
              state <= WRITE;
            end
          end
        end
        WRITE: begin
          vld_p1 <= 1'b1;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // ---- stage p0 -> p1: capture the merged word for the WRITE cycle ----
  // Merge data is only consumed in WRITE, so it carries no reset.
  always_ff @(posedge clk) begin
    if (store_sub_fire) begin
      wr_addr_p1 <= word_addr;
      wr_data_p1 <= store_merge(mem_RD, req_wdata, req_funct3, req_addr[1:0]);
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
`timescale 1ns/1ps
// Directed, scoreboard-based bench for load_store_unit with a behavioural Data_Memory.
module tb_load_store_unit;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_misalign;
  logic [31:0] mem_A;
  logic [31:0] mem_WD;
  logic        mem_MemWrite;
  logic [31:0] mem_RD;

  typedef struct {
    logic [31:0] rd;
    logic        mis;
  } exp_t;

  exp_t sb[$];
  int   passed = 0;
  int   total  = 0;

  logic [31:0] tbmem [0:15];

  load_store_unit #(.ADDR_W(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_funct3   (req_funct3),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .rsp_misalign (rsp_misalign),
    .mem_A        (mem_A),
    .mem_WD       (mem_WD),
    .mem_MemWrite (mem_MemWrite),
    .mem_RD       (mem_RD)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Data_Memory model: combinational read, word write on the rising edge.
  assign mem_RD = tbmem[mem_A[5:2]];
  always @(posedge clk) begin
    if (mem_MemWrite) tbmem[mem_A[5:2]] <= mem_WD;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic pop_check(input string tag);
    exp_t e;
    if (sb.size() != 0) e = sb.pop_front();
    else begin
      e.rd  = 32'hDEADDEAD;
      e.mis = 1'b1;
    end
    check({tag, " rdata"}, rsp_rdata, e.rd);
    check({tag, " misalign"}, {31'b0, rsp_misalign}, {31'b0, e.mis});
  endtask

  // Issue one request at posedge+1, then wait (bounded) for its response.
  task automatic do_req(input string tag, input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_rd, input logic exp_mis, input int exp_lat);
    exp_t e;
    int   lat;
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    e.rd  = exp_rd;
    e.mis = exp_mis;
    sb.push_back(e);
    @(negedge clk);
    check({tag, " ready"}, {31'b0, req_ready}, 32'd1);
    check({tag, " mem_A"}, mem_A, {addr[31:2], 2'b00});
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    lat = 0;
    for (int i = 1; i <= 4 && lat == 0; i++) begin
      @(negedge clk);
      if (rsp_valid) begin
        lat = i;
        pop_check(tag);
      end else begin
        if (i == 1 && exp_lat == 2) begin
          check({tag, " busy ready"}, {31'b0, req_ready}, 32'd0);
          check({tag, " busy write"}, {31'b0, mem_MemWrite}, 32'd1);
        end
        @(posedge clk);
        #1;
      end
    end
    check({tag, " latency"}, lat, exp_lat);
    if (lat == 0 && sb.size() != 0) void'(sb.pop_front());
    @(posedge clk);
    #1;
    check({tag, " pulse"}, {31'b0, rsp_valid}, 32'd0);
  endtask

  initial begin
    exp_t e;
    logic seen;
    rst        = 1'b1;
    req_valid  = 1'b1;
    req_we     = 1'b1;
    req_funct3 = 3'b010;
    req_addr   = 32'h8;
    req_wdata  = 32'hFFFF_FFFF;

    // Reset: everything gated to zero even with a store presented.
    #2;
    check("rst ready", {31'b0, req_ready}, 32'd0);
    check("rst memwrite", {31'b0, mem_MemWrite}, 32'd0);
    check("rst mem_A", mem_A, 32'd0);
    check("rst mem_WD", mem_WD, 32'd0);
    check("rst rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("rst rdata", rsp_rdata, 32'd0);
    check("rst misalign", {31'b0, rsp_misalign}, 32'd0);
    req_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("post-rst ready", {31'b0, req_ready}, 32'd1);
    check("post-rst memwrite", {31'b0, mem_MemWrite}, 32'd0);
    @(posedge clk);
    #1;

    // Word store / load.
    do_req("sw8", 1'b1, 3'b010, 32'h8, 32'hAAAA_BBBB, 32'h0, 1'b0, 1);
    do_req("lw8", 1'b0, 3'b010, 32'h8, 32'h0, 32'hAAAA_BBBB, 1'b0, 1);

    // Byte store with read-modify-write.
    do_req("sb9", 1'b1, 3'b000, 32'h9, 32'h0000_00EE, 32'h0, 1'b0, 2);
    check("sb9 word", tbmem[2], 32'hAAAA_EEBB);
    do_req("lbu9", 1'b0, 3'b100, 32'h9, 32'h0, 32'h0000_00EE, 1'b0, 1);
    do_req("lb9", 1'b0, 3'b000, 32'h9, 32'h0, 32'hFFFF_FFEE, 1'b0, 1);

    // Halfword store.
    do_req("sw12", 1'b1, 3'b010, 32'hC, 32'hCCCC_DDDD, 32'h0, 1'b0, 1);
    do_req("sh14", 1'b1, 3'b001, 32'hE, 32'h0000_1234, 32'h0, 1'b0, 2);
    check("sh14 word", tbmem[3], 32'h1234_DDDD);
    do_req("lh12", 1'b0, 3'b001, 32'hC, 32'h0, 32'hFFFF_DDDD, 1'b0, 1);
    do_req("lhu14", 1'b0, 3'b101, 32'hE, 32'h0, 32'h0000_1234, 1'b0, 1);

    // Misaligned word load.
`ifdef LSU_MISALIGN_TRAP_EN
    do_req("lw10", 1'b0, 3'b010, 32'hA, 32'h0, 32'h0, 1'b1, 1);
    do_req("sw9 trap", 1'b1, 3'b010, 32'h9, 32'h5555_5555, 32'h0, 1'b1, 1);
    check("sw9 trap word", tbmem[2], 32'hAAAA_EEBB);
`else
    do_req("lw10", 1'b0, 3'b010, 32'hA, 32'h0, 32'hAAAA_EEBB, 1'b0, 1);
`endif

    // Illegal funct3 store: no write, zero response.
    do_req("ill011", 1'b1, 3'b011, 32'h8, 32'hDEAD_BEEF, 32'h0, 1'b0, 1);
    check("ill011 word", tbmem[2], 32'hAAAA_EEBB);

    // Back-to-back loads: second accepted while first response is out.
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b000; req_addr = 32'h8;
    e.rd = 32'hFFFF_FFBB; e.mis = 1'b0; sb.push_back(e);
    @(negedge clk);
    check("b2b ready0", {31'b0, req_ready}, 32'd1);
    @(posedge clk);
    #1;
    req_funct3 = 3'b101; req_addr = 32'hA;
    e.rd = 32'h0000_AAAA; e.mis = 1'b0; sb.push_back(e);
    @(negedge clk);
    check("b2b vld0", {31'b0, rsp_valid}, 32'd1);
    pop_check("b2b lb8");
    check("b2b ready1", {31'b0, req_ready}, 32'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    check("b2b vld1", {31'b0, rsp_valid}, 32'd1);
    pop_check("b2b lhu10");
    @(posedge clk);
    #1;

    // Reset during the WRITE cycle of a byte store.
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b000; req_addr = 32'h8;
    req_wdata = 32'h0000_0011;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    check("rdw write", {31'b0, mem_MemWrite}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("rdw drop", {31'b0, mem_MemWrite}, 32'd0);
    check("rdw ready", {31'b0, req_ready}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (rsp_valid) seen = 1'b1;
    end
    check("rdw no rsp", {31'b0, seen}, 32'd0);
    check("rdw word", tbmem[2], 32'hAAAA_EEBB);
    @(posedge clk);
    #1;
    do_req("lw8 after", 1'b0, 3'b010, 32'h8, 32'h0, 32'hAAAA_EEBB, 1'b0, 1);
    check("queue empty", sb.size(), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
